// File: rtl/nibble_serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl_pkg
// Brief    : Shared state encodings and slice width for the nibble-serial
//            adder sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_ctrl_pkg;

  // Width of the shared adder slice, in bits
  localparam int NIBBLE = 4;

  // Sequencer states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fullAdder4bit.sv
`default_nettype none
// ============================================================================
// Module   : fullAdder4bit
// Brief    : Purely combinational 4-bit full adder slice shared by the
//            nibble-serial sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module fullAdder4bit (
  output logic       carry_out,
  output logic [3:0] sum,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in
);

  // Zero-extend to 5 bits so the top bit of the add is the carry out
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, carry_in};

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Brief    : Adds two WIDTH-bit operands over WIDTH/4 clocks through one
//            4-bit adder slice, carry rippling through a flop between
//            nibbles. Operands in and the result out use valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  import nibble_serial_adder_ctrl_pkg::*;

  // Counter value of the final (most significant) nibble step
  localparam logic [CNT_W-1:0] c_last_nibble = CNT_W'(WIDTH / NIBBLE - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       w_nib_sum;
  logic             w_nib_cout;
  logic             w_last;

  assign w_last    = (r_cnt == c_last_nibble);
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);

  // The single shared slice always sees the low nibble of each shift register
  fullAdder4bit u_slice (
    .carry_out (w_nib_cout),
    .sum       (w_nib_sum),
    .a         (r_a_sh[NIBBLE-1:0]),
    .b         (r_b_sh[NIBBLE-1:0]),
    .carry_in  (r_carry)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; DONE always returns to IDLE so accept and consume never share a cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_next_state = ST_RUN;
      ST_RUN:  if (w_last)    w_next_state = ST_DONE;
      ST_DONE: if (out_ready) w_next_state = ST_IDLE;
      default:                w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then one nibble step per RUN cycle; DONE holds the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_a_sh  <= r_a_sh >> NIBBLE;
          r_b_sh  <= r_b_sh >> NIBBLE;
          r_carry <= w_nib_cout;
          sum     <= {w_nib_sum, sum[WIDTH-1:NIBBLE]};
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            cout <= w_nib_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Brief    : Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16):
//            vector table, random vectors, back-pressure, mid-run reset and
//            back-to-back requests, with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH), .CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] es;
    logic             ec;
  } vec_t;

  res_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a result is compared when it is handed over (out_valid && out_ready)
  always @(negedge clk) begin
    res_t e;
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum=0x%04h cout=%0b, expected none", sum, cout);
      end else begin
        e = q.pop_front();
        $display("trace cyc=%0d sum=0x%04h cout=%0b", cyc, sum, cout);
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
      end
    end
  end

  // Present one operand pair until accepted; optionally queue its expected result
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc,
                      input logic [WIDTH-1:0] es, input logic ec, input bit push);
    int n = 0;
    res_t r;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (push) begin
      r.s = es;
      r.c = ec;
      q.push_back(r);
    end
  endtask

  // Count clock edges from the accept edge until out_valid is seen
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  vec_t vecs[8];
  int   lat;
  int   acc;
  int   acc_cyc[2];
  logic [WIDTH:0] wide;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h5A5A, 16'hA5A5, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{16'h5A5A, 16'hA5A5, 1'b0, 16'hFFFF, 1'b0};
    vecs[4] = '{16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[7] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    reset = 1'b0;
    tick();

    // out_ready while nothing is valid must not disturb anything
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_out_ready_in_ready", 32'(in_ready), 32'd1);

    // Table: the result appears 4 edges after the accept edge (fifth cycle counting the accept cycle)
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].es, vecs[i].ec, 1'b1);
      wait_valid(lat);
      chk("latency", 32'(lat), 32'd4);
      consume();
    end

    // Random vectors against an arithmetic model
    for (int i = 0; i < 6; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic rc;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom_range(0, 1));
      wide = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      send(ra, rb, rc, wide[WIDTH-1:0], wide[WIDTH], 1'b1);
      wait_valid(lat);
      consume();
    end

    // Back-pressure, with ignored requests during RUN
    send(16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0, 1'b1);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("run_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    wait_valid(lat);
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h2143);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    consume();
    chk("after_consume_out_valid", 32'(out_valid), 32'd0);
    chk("after_consume_in_ready", 32'(in_ready), 32'd1);

    // Reset during the second RUN cycle aborts the transaction
    send(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    send(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b1);
    wait_valid(lat);
    chk("post_abort_latency", 32'(lat), 32'd4);
    consume();

    // Back-to-back with in_valid and out_ready held high
    acc = 0;
    out_ready = 1'b1;
    a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 30 && acc < 2; i++) begin
      if (in_ready) begin
        res_t r;
        acc_cyc[acc] = cyc + 1;
        r.s = (acc == 0) ? 16'h0002 : 16'h0000;
        r.c = (acc == 0) ? 1'b0 : 1'b1;
        q.push_back(r);
        acc++;
      end
      tick();
      if (acc == 1) begin
        a = 16'h8000; b = 16'h8000;
      end
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd2);
    if (acc == 2) chk("b2b_period", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    out_ready = 1'b0;
    tick();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
